// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port datapath memory between the CPU and
// the program loader. A request is accepted in IDLE, granted for one cycle,
// issued to memory for one cycle, and completed after MEM_LAT cycles with a
// Done pulse; read data is held in a per-requester register.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; left undefined, the CPU has fixed priority.
module mem_port_arbiter #(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          CpuReq,
    input  logic          CpuWr,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWdata,
    output logic          CpuGnt,
    output logic          CpuDone,
    output logic [DW-1:0] CpuRdata,
    input  logic          LdReq,
    input  logic          LdWr,
    input  logic [AW-1:0] LdAddr,
    input  logic [DW-1:0] LdWdata,
    output logic          LdGnt,
    output logic          LdDone,
    output logic [DW-1:0] LdRdata,
    output logic          MemEn,
    output logic          MemWr,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    output logic          Busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Owner encoding: 0 = CPU, 1 = loader.
    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_LD   = 1'b1;
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    state_t     state;
    logic       owner;
    logic [2:0] lat_cnt;
    logic       pick_ld;   // 1 when the loader wins the current IDLE arbitration

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ld;         // 1 when the loader won the most recent grant
    logic accept;

    assign accept = (state == IDLE) && (CpuReq || LdReq);

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        pick_ld = 1'b0;
        if (CpuReq && LdReq) begin
            pick_ld = !last_ld;
        end else begin
            pick_ld = LdReq;
        end
    end

    // Remember the last winner; reset favours the CPU on the first tie.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_ld <= OWN_LD;
        end else if (accept) begin
            last_ld <= pick_ld;
        end
    end
`else
    // Fixed priority: the loader only wins when the CPU is not asking.
    assign pick_ld = LdReq && !CpuReq;
`endif

    // Access sequencer with registered strobes; pulses default low each cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            owner    <= OWN_CPU;
            lat_cnt  <= '0;
            CpuGnt   <= 1'b0;
            LdGnt    <= 1'b0;
            CpuDone  <= 1'b0;
            LdDone   <= 1'b0;
            MemEn    <= 1'b0;
            MemWr    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
            CpuRdata <= '0;
            LdRdata  <= '0;
            Busy     <= 1'b0;
        end else begin
            CpuGnt  <= 1'b0;
            LdGnt   <= 1'b0;
            CpuDone <= 1'b0;
            LdDone  <= 1'b0;
            MemEn   <= 1'b0;
            case (state)
                IDLE: begin
                    if (CpuReq || LdReq) begin
                        owner    <= pick_ld;
                        MemWr    <= pick_ld ? LdWr    : CpuWr;
                        MemAddr  <= pick_ld ? LdAddr  : CpuAddr;
                        MemWdata <= pick_ld ? LdWdata : CpuWdata;
                        CpuGnt   <= !pick_ld;
                        LdGnt    <= pick_ld;
                        Busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    MemEn <= 1'b1;
                    state <= ACCESS;
                end
                ACCESS: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        if (!MemWr) begin
                            if (owner == OWN_LD) begin
                                LdRdata <= MemRdata;
                            end else begin
                                CpuRdata <= MemRdata;
                            end
                        end
                        CpuDone <= (owner == OWN_CPU);
                        LdDone  <= (owner == OWN_LD);
                        state   <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3),
// each backed by a behavioural memory, exercised by directed scenarios and by
// randomized requesters checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic Clock;
    logic Reset;

    // Index [d][r]: d = instance (0: MEM_LAT=1, 1: MEM_LAT=3), r = 0 CPU / 1 loader.
    logic       req   [2][2];
    logic       wr    [2][2];
    logic [4:0] addr  [2][2];
    logic [7:0] wdata [2][2];
    logic       gnt   [2][2];
    logic       done  [2][2];
    logic [7:0] rdata [2][2];

    logic       mem_en    [2];
    logic       mem_wr    [2];
    logic [4:0] mem_addr  [2];
    logic [7:0] mem_wdata [2];
    logic [7:0] mem_rdata [2];
    logic       busy      [2];

    int n_cmp = 0;
    int n_bad = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    mem_port_arbiter #(.AW(5), .DW(8), .MEM_LAT(1)) dut1 (
        .Clock(Clock), .Reset(Reset),
        .CpuReq(req[0][0]), .CpuWr(wr[0][0]), .CpuAddr(addr[0][0]), .CpuWdata(wdata[0][0]),
        .CpuGnt(gnt[0][0]), .CpuDone(done[0][0]), .CpuRdata(rdata[0][0]),
        .LdReq(req[0][1]), .LdWr(wr[0][1]), .LdAddr(addr[0][1]), .LdWdata(wdata[0][1]),
        .LdGnt(gnt[0][1]), .LdDone(done[0][1]), .LdRdata(rdata[0][1]),
        .MemEn(mem_en[0]), .MemWr(mem_wr[0]), .MemAddr(mem_addr[0]), .MemWdata(mem_wdata[0]),
        .MemRdata(mem_rdata[0]), .Busy(busy[0])
    );

    mem_port_arbiter #(.AW(5), .DW(8), .MEM_LAT(3)) dut3 (
        .Clock(Clock), .Reset(Reset),
        .CpuReq(req[1][0]), .CpuWr(wr[1][0]), .CpuAddr(addr[1][0]), .CpuWdata(wdata[1][0]),
        .CpuGnt(gnt[1][0]), .CpuDone(done[1][0]), .CpuRdata(rdata[1][0]),
        .LdReq(req[1][1]), .LdWr(wr[1][1]), .LdAddr(addr[1][1]), .LdWdata(wdata[1][1]),
        .LdGnt(gnt[1][1]), .LdDone(done[1][1]), .LdRdata(rdata[1][1]),
        .MemEn(mem_en[1]), .MemWr(mem_wr[1]), .MemAddr(mem_addr[1]), .MemWdata(mem_wdata[1]),
        .MemRdata(mem_rdata[1]), .Busy(busy[1])
    );

    // Behavioural memories: reloaded with a known pattern on Reset, read data
    // appears exactly MEM_LAT cycles after MemEn, random junk otherwise.
    logic [7:0] mem  [2][32];
    logic [7:0] pipe [2][7];
    logic       pv   [2][7];
    logic [7:0] junk;

    function automatic logic [7:0] init_val(input int a);
        return 8'(32'hA2 + a);
    endfunction

    always @(posedge Clock) begin
        junk <= 8'($urandom);
        for (int d = 0; d < 2; d++) begin
            for (int s = 6; s > 0; s--) begin
                pipe[d][s] <= pipe[d][s-1];
                pv[d][s]   <= pv[d][s-1];
            end
            pipe[d][0] <= mem[d][mem_addr[d]];
            pv[d][0]   <= mem_en[d] && !mem_wr[d];
            if (Reset) begin
                for (int a = 0; a < 32; a++) mem[d][a] <= init_val(a);
            end else if (mem_en[d] && mem_wr[d]) begin
                mem[d][mem_addr[d]] <= mem_wdata[d];
            end
        end
    end

    always_comb begin
        mem_rdata[0] = pv[0][0] ? pipe[0][0] : junk;
        mem_rdata[1] = pv[1][2] ? pipe[1][2] : junk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                req[d][r] = 1'b0; wr[d][r] = 1'b0; addr[d][r] = 5'h0; wdata[d][r] = 8'h0;
            end
        end
    endtask

    // Leaves the bench at the negedge of the first cycle after reset (IDLE).
    task automatic do_reset();
        clear_inputs();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        req[0][0] = 1'b1;
        req[1][1] = 1'b1;
        Reset = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if ({gnt[d][0], gnt[d][1], done[d][0], done[d][1], mem_en[d], mem_wr[d], busy[d]} !== 7'b0) begin
                    n_bad++;
                    $display("FAIL reset_ctrl d%0d: got %b want 0000000", d,
                             {gnt[d][0], gnt[d][1], done[d][0], done[d][1], mem_en[d], mem_wr[d], busy[d]});
                end
                n_cmp++;
                if ({mem_addr[d], mem_wdata[d], rdata[d][0], rdata[d][1]} !== 29'b0) begin
                    n_bad++;
                    $display("FAIL reset_data d%0d: got %h want 0", d,
                             {mem_addr[d], mem_wdata[d], rdata[d][0], rdata[d][1]});
                end
            end
        end
        Reset = 1'b0;
        n_cmp++;
        if ({busy[0], gnt[0][0], busy[1], gnt[1][1]} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_first_idle: got %b want 0000", {busy[0], gnt[0][0], busy[1], gnt[1][1]});
        end
        @(negedge Clock);
        n_cmp++;
        if ({gnt[0][0], gnt[0][1], gnt[1][0], gnt[1][1]} !== 4'b1001) begin
            n_bad++;
            $display("FAIL reset_held_req_gnt: got %b want 1001", {gnt[0][0], gnt[0][1], gnt[1][0], gnt[1][1]});
        end
    endtask

    task automatic test_cpu_read();
        do_reset();
        req[0][0] = 1'b1; wr[0][0] = 1'b0; addr[0][0] = 5'h03;
        for (int c = 1; c <= 7; c++) begin
            @(negedge Clock);
            n_cmp++;
            if (gnt[0][0] !== (c == 1)) begin
                n_bad++; $display("FAIL t1_cpu_gnt c%0d: got %0b want %0b", c, gnt[0][0], c == 1);
            end
            n_cmp++;
            if (mem_en[0] !== (c == 2)) begin
                n_bad++; $display("FAIL t1_mem_en c%0d: got %0b want %0b", c, mem_en[0], c == 2);
            end
            n_cmp++;
            if (done[0][0] !== (c == 4)) begin
                n_bad++; $display("FAIL t1_cpu_done c%0d: got %0b want %0b", c, done[0][0], c == 4);
            end
            n_cmp++;
            if ({gnt[0][1], done[0][1]} !== 2'b00) begin
                n_bad++; $display("FAIL t1_ld_quiet c%0d: got %b want 00", c, {gnt[0][1], done[0][1]});
            end
            if (c == 2) begin
                n_cmp++;
                if ({mem_wr[0], mem_addr[0]} !== {1'b0, 5'h03}) begin
                    n_bad++; $display("FAIL t1_mem_port: got %h want %h", {mem_wr[0], mem_addr[0]}, {1'b0, 5'h03});
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (rdata[0][0] !== 8'hA5) begin
                    n_bad++; $display("FAIL t1_cpu_rdata: got %h want a5", rdata[0][0]);
                end
                req[0][0] = 1'b0;
            end
        end
    endtask

    task automatic test_ld_write();
        logic [7:0] exp_rd;
        do_reset();
        req[0][1] = 1'b1; wr[0][1] = 1'b0; addr[0][1] = 5'h04;
        for (int c = 1; c <= 11; c++) begin
            @(negedge Clock);
            exp_rd = (c >= 4) ? 8'hA6 : 8'h00;
            n_cmp++;
            if (gnt[0][1] !== (c == 1 || c == 6)) begin
                n_bad++; $display("FAIL t2_ld_gnt c%0d: got %0b want %0b", c, gnt[0][1], c == 1 || c == 6);
            end
            n_cmp++;
            if (mem_en[0] !== (c == 2 || c == 7)) begin
                n_bad++; $display("FAIL t2_mem_en c%0d: got %0b want %0b", c, mem_en[0], c == 2 || c == 7);
            end
            n_cmp++;
            if (done[0][1] !== (c == 4 || c == 9)) begin
                n_bad++; $display("FAIL t2_ld_done c%0d: got %0b want %0b", c, done[0][1], c == 4 || c == 9);
            end
            n_cmp++;
            if (rdata[0][1] !== exp_rd) begin
                n_bad++; $display("FAIL t2_ld_rdata c%0d: got %h want %h", c, rdata[0][1], exp_rd);
            end
            n_cmp++;
            if (gnt[0][0] !== 1'b0) begin
                n_bad++; $display("FAIL t2_cpu_gnt c%0d: got %0b want 0", c, gnt[0][0]);
            end
            if (c == 7) begin
                n_cmp++;
                if ({mem_wr[0], mem_addr[0], mem_wdata[0]} !== {1'b1, 5'h1F, 8'h3C}) begin
                    n_bad++;
                    $display("FAIL t2_mem_write: got %h want %h", {mem_wr[0], mem_addr[0], mem_wdata[0]}, {1'b1, 5'h1F, 8'h3C});
                end
            end
            // Back-to-back: keep LdReq high and present the write right after the read completes.
            if (c == 4) begin
                wr[0][1] = 1'b1; addr[0][1] = 5'h1F; wdata[0][1] = 8'h3C;
            end
            if (c == 9) req[0][1] = 1'b0;
        end
    endtask

    task automatic test_contention();
        int seq [4] = '{-1, -1, -1, -1};
        int n = 0;
        int exp_w;
        bit seen;
        do_reset();
        req[0][0] = 1'b1; addr[0][0] = 5'h01;
        req[0][1] = 1'b1; addr[0][1] = 5'h02;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge Clock);
            n_cmp++;
            if (gnt[0][0] && gnt[0][1]) begin
                n_bad++; $display("FAIL t3_gnt_exclusive c%0d: got 11 want not both", c);
            end
            if (gnt[0][0]) begin
                seq[n] = 0; n++;
            end else if (gnt[0][1]) begin
                seq[n] = 1; n++;
            end
        end
        n_cmp++;
        if (n != 4) begin
            n_bad++; $display("FAIL t3_grant_count: got %0d want 4", n);
        end
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_w = i % 2;
`else
            exp_w = 0;
`endif
            n_cmp++;
            if (seq[i] != exp_w) begin
                n_bad++; $display("FAIL t3_winner_%0d: got %0d want %0d", i, seq[i], exp_w);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clock);
            seen = done[0][0] || done[0][1];
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL t3_final_done: got none want done within 10 cycles");
        end
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
    endtask

    task automatic test_lat3_addr_hold();
        do_reset();
        req[1][0] = 1'b1; wr[1][0] = 1'b0; addr[1][0] = 5'h07;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            n_cmp++;
            if (gnt[1][0] !== (c == 1)) begin
                n_bad++; $display("FAIL t4_cpu_gnt c%0d: got %0b want %0b", c, gnt[1][0], c == 1);
            end
            n_cmp++;
            if (mem_en[1] !== (c == 2)) begin
                n_bad++; $display("FAIL t4_mem_en c%0d: got %0b want %0b", c, mem_en[1], c == 2);
            end
            n_cmp++;
            if (done[1][0] !== (c == 6)) begin
                n_bad++; $display("FAIL t4_cpu_done c%0d: got %0b want %0b", c, done[1][0], c == 6);
            end
            n_cmp++;
            if (mem_addr[1] !== 5'h07) begin
                n_bad++; $display("FAIL t4_mem_addr_hold c%0d: got %h want 07", c, mem_addr[1]);
            end
            if (c == 1) addr[1][0] = 5'h15;
            if (c == 6) begin
                n_cmp++;
                if (rdata[1][0] !== 8'hA9) begin
                    n_bad++; $display("FAIL t4_cpu_rdata: got %h want a9", rdata[1][0]);
                end
                req[1][0] = 1'b0;
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req[0][0] = 1'b1; wr[0][0] = 1'b0; addr[0][0] = 5'h09;
        for (int c = 1; c <= 9; c++) begin
            @(negedge Clock);
            n_cmp++;
            if (gnt[0][0] !== (c == 1 || c == 5)) begin
                n_bad++; $display("FAIL t5_cpu_gnt c%0d: got %0b want %0b", c, gnt[0][0], c == 1 || c == 5);
            end
            n_cmp++;
            if (done[0][0] !== (c == 8)) begin
                n_bad++; $display("FAIL t5_cpu_done c%0d: got %0b want %0b", c, done[0][0], c == 8);
            end
            n_cmp++;
            if (busy[0] !== ((c >= 1 && c <= 3) || (c >= 5 && c <= 8))) begin
                n_bad++; $display("FAIL t5_busy c%0d: got %0b want %0b", c, busy[0], (c >= 1 && c <= 3) || (c >= 5 && c <= 8));
            end
            if (c == 3) begin
                n_cmp++;
                if (mem_addr[0] !== 5'h09) begin
                    n_bad++; $display("FAIL t5_addr_before_reset: got %h want 09", mem_addr[0]);
                end
                Reset = 1'b1;
            end
            if (c == 4) begin
                n_cmp++;
                if ({mem_en[0], mem_addr[0]} !== 6'h00) begin
                    n_bad++; $display("FAIL t5_after_reset: got %h want 00", {mem_en[0], mem_addr[0]});
                end
                Reset = 1'b0;
            end
            if (c == 8) begin
                n_cmp++;
                if (rdata[0][0] !== 8'hAB) begin
                    n_bad++; $display("FAIL t5_cpu_rdata: got %h want ab", rdata[0][0]);
                end
                req[0][0] = 1'b0;
            end
        end
    endtask

    task automatic test_drop_req();
        do_reset();
        req[0][0] = 1'b1; wr[0][0] = 1'b1; addr[0][0] = 5'h0A; wdata[0][0] = 8'h77;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clock);
            n_cmp++;
            if (gnt[0][0] !== (c == 1)) begin
                n_bad++; $display("FAIL t6_cpu_gnt c%0d: got %0b want %0b", c, gnt[0][0], c == 1);
            end
            n_cmp++;
            if (mem_en[0] !== (c == 2)) begin
                n_bad++; $display("FAIL t6_mem_en c%0d: got %0b want %0b", c, mem_en[0], c == 2);
            end
            n_cmp++;
            if (done[0][0] !== (c == 4)) begin
                n_bad++; $display("FAIL t6_cpu_done c%0d: got %0b want %0b", c, done[0][0], c == 4);
            end
            if (c == 1) req[0][0] = 1'b0;
        end
    endtask

    // Randomized requesters on instance d. The model is a transaction timeline:
    // an access accepted when the arbiter is free at cycle k grants at k+1,
    // strobes memory at k+2, completes at k+3+lat, and frees the port at k+4+lat.
    task automatic test_random(input int d, input int ncyc);
        int lat;
        int st [2];            // 0 idle, 1 requesting, 2 dropped and awaiting Done
        logic [7:0] ref_mem [32];
        logic [7:0] ref_rd [2];
        bit active;
        bit allow;
        int free_cyc, g_cyc, e_cyc, d_cyc, who, last_who;
        logic t_wr;
        logic [4:0] t_addr;
        logic [7:0] t_wd;
        lat = (d == 0) ? 1 : 3;
        do_reset();
        for (int a = 0; a < 32; a++) ref_mem[a] = init_val(a);
        ref_rd[0] = 8'h00; ref_rd[1] = 8'h00;
        st[0] = 0; st[1] = 0;
        active = 1'b0; free_cyc = 0; g_cyc = -1; e_cyc = -1; d_cyc = -1;
        who = 0; last_who = 1; t_wr = 1'b0; t_addr = 5'h0; t_wd = 8'h0;
        for (int k = 0; k < ncyc; k++) begin
            allow = (k < ncyc - 20);
            if (active && k == e_cyc) begin
                n_cmp++;
                if ({mem_wr[d], mem_addr[d], mem_wdata[d]} !== {t_wr, t_addr, t_wd}) begin
                    n_bad++;
                    $display("FAIL rand%0d_mem_port k%0d: got %h want %h", d, k, {mem_wr[d], mem_addr[d], mem_wdata[d]}, {t_wr, t_addr, t_wd});
                end
                if (t_wr) ref_mem[t_addr] = t_wd;
            end
            if (active && k == d_cyc && !t_wr) ref_rd[who] = ref_mem[t_addr];
            n_cmp++;
            if (mem_en[d] !== (active && k == e_cyc)) begin
                n_bad++; $display("FAIL rand%0d_mem_en k%0d: got %0b want %0b", d, k, mem_en[d], active && k == e_cyc);
            end
            n_cmp++;
            if (busy[d] !== (active && k >= g_cyc && k <= d_cyc)) begin
                n_bad++; $display("FAIL rand%0d_busy k%0d: got %0b want %0b", d, k, busy[d], active && k >= g_cyc && k <= d_cyc);
            end
            for (int r = 0; r < 2; r++) begin
                n_cmp++;
                if (gnt[d][r] !== (active && k == g_cyc && who == r)) begin
                    n_bad++; $display("FAIL rand%0d_gnt%0d k%0d: got %0b want %0b", d, r, k, gnt[d][r], active && k == g_cyc && who == r);
                end
                n_cmp++;
                if (done[d][r] !== (active && k == d_cyc && who == r)) begin
                    n_bad++; $display("FAIL rand%0d_done%0d k%0d: got %0b want %0b", d, r, k, done[d][r], active && k == d_cyc && who == r);
                end
                n_cmp++;
                if (rdata[d][r] !== ref_rd[r]) begin
                    n_bad++; $display("FAIL rand%0d_rdata%0d k%0d: got %h want %h", d, r, k, rdata[d][r], ref_rd[r]);
                end
            end
            if (active && k == d_cyc) begin
                active = 1'b0;
                if (st[who] == 1 && allow && $urandom_range(0, 1) == 1) begin
                    addr[d][who] = 5'($urandom); wdata[d][who] = 8'($urandom);
                end else begin
                    st[who] = 0; req[d][who] = 1'b0;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (st[r] == 0 && allow && $urandom_range(0, 2) == 0) begin
                    st[r] = 1; req[d][r] = 1'b1; wr[d][r] = 1'($urandom);
                    addr[d][r] = 5'($urandom); wdata[d][r] = 8'($urandom);
                end else if (st[r] == 1 && active && who == r && k >= g_cyc) begin
                    if ($urandom_range(0, 3) == 0) begin
                        addr[d][r] = 5'($urandom); wdata[d][r] = 8'($urandom);
                    end
                    if ($urandom_range(0, 7) == 0) begin
                        st[r] = 2; req[d][r] = 1'b0;
                    end
                end
            end
            if (!active && k >= free_cyc && (req[d][0] || req[d][1])) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (req[d][0] && req[d][1]) who = 1 - last_who;
                else who = req[d][0] ? 0 : 1;
`else
                who = req[d][0] ? 0 : 1;
`endif
                last_who = who;
                active = 1'b1;
                g_cyc = k + 1; e_cyc = k + 2; d_cyc = k + 3 + lat; free_cyc = k + 4 + lat;
                t_wr = wr[d][who]; t_addr = addr[d][who]; t_wd = wdata[d][who];
            end
            @(negedge Clock);
        end
        clear_inputs();
    endtask

    initial begin
        Reset = 1'b1;
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_ld_write();
        test_contention();
        test_lat3_addr_hold();
        test_mid_reset();
        test_drop_req();
        test_random(0, 500);
        test_random(1, 500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
